// File: rtl/uart_rib_if.sv
// RIB slave-port bundle for the UART register block.
interface uart_rib_if;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (output we_i, addr_i, data_i, input data_o);
  modport slave  (input we_i, addr_i, data_i, output data_o);
endinterface

// File: rtl/uart_rib.sv
// UART with RIB register interface: 8N1 transmitter and receiver with
// programmable bit period, sticky RX flags and a small register map.
//
// TX states
//   state    | meaning
//   TX_IDLE  | line high, waiting for an accepted TXDATA write
//   TX_START | driving start bit (0) for one period
//   TX_DATA  | driving data bits LSB first, one period each
//   TX_STOP  | driving stop bit (1) for one period
//
// RX states
//   state    | meaning
//   RX_IDLE  | waiting for a synchronized falling edge
//   RX_START | waiting half a period to confirm the start bit
//   RX_DATA  | sampling 8 data bits, one period apart
//   RX_STOP  | sampling the stop bit one period after the last data bit
module uart_rib #(
  parameter logic [15:0] BAUD_RST = 16'd434,
  parameter int          ADDR_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  uart_rib_if.slave  bus,
  output logic       tx_pin,
  input  logic       rx_pin
);

  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(8'h04);
  localparam logic [ADDR_W-1:0] A_BAUD = ADDR_W'(8'h08);
  localparam logic [ADDR_W-1:0] A_TXD  = ADDR_W'(8'h0C);
  localparam logic [ADDR_W-1:0] A_RXD  = ADDR_W'(8'h10);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic              tx_en, rx_en;
  logic [15:0]       baud;
  logic              rx_valid, rx_overrun;
  logic [7:0]        rx_data;

  logic [ADDR_W-1:0] off;
  logic              wr_ctrl, wr_stat, wr_baud, wr_txd;
  logic [15:0]       period, half;
  logic              unused_bits;

  tx_state_t         tx_state, tx_state_n;
  logic [15:0]       tx_cnt, tx_cnt_n;
  logic [2:0]        tx_idx, tx_idx_n;
  logic [7:0]        tx_shift, tx_shift_n;
  logic              tx_busy;

  rx_state_t         rx_state, rx_state_n;
  logic [15:0]       rx_cnt, rx_cnt_n;
  logic [2:0]        rx_idx, rx_idx_n;
  logic [7:0]        rx_shift, rx_shift_n;
  logic              rx_s1, rx_s2, rx_s3;
  logic              rx_done;

  assign off         = bus.addr_i[ADDR_W-1:0];
  assign wr_ctrl     = bus.we_i && (off == A_CTRL);
  assign wr_stat     = bus.we_i && (off == A_STAT);
  assign wr_baud     = bus.we_i && (off == A_BAUD);
  assign wr_txd      = bus.we_i && (off == A_TXD);
  assign unused_bits = ^{bus.addr_i[31:ADDR_W], bus.data_i[31:16]};

  // Bit period is clamped to at least 4 cycles so the half-period is never 0.
  assign period  = (baud < 16'd4) ? 16'd4 : baud;
  assign half    = {1'b0, period[15:1]};
  assign tx_busy = (tx_state != TX_IDLE);

  // Register read mux; purely combinational, no read side effects.
  always_comb begin
    bus.data_o = 32'd0;
    case (off)
      A_CTRL:  bus.data_o = {30'd0, rx_en, tx_en};
      A_STAT:  bus.data_o = {29'd0, rx_overrun, rx_valid, tx_busy};
      A_BAUD:  bus.data_o = {16'd0, baud};
      A_RXD:   bus.data_o = {24'd0, rx_data};
      default: bus.data_o = 32'd0;
    endcase
  end

  // Configuration and RX flag registers; a byte completion beats a same-cycle W1C.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_en      <= 1'b0;
      rx_en      <= 1'b0;
      baud       <= BAUD_RST;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      rx_data    <= 8'd0;
    end else begin
      if (wr_ctrl) {rx_en, tx_en} <= bus.data_i[1:0];
      if (wr_baud) baud <= bus.data_i[15:0];
      if (rx_done) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
        if (rx_valid && !(wr_stat && bus.data_i[1])) rx_overrun <= 1'b1;
        else if (wr_stat && bus.data_i[2])           rx_overrun <= 1'b0;
      end else begin
        if (wr_stat && bus.data_i[1]) rx_valid   <= 1'b0;
        if (wr_stat && bus.data_i[2]) rx_overrun <= 1'b0;
      end
    end
  end

  // TX state, counter and shift register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= 16'd0;
      tx_idx   <= 3'd0;
      tx_shift <= 8'd0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_shift <= tx_shift_n;
    end
  end

  // TX next-state and line drive; the period is re-read at every reload.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_idx_n   = tx_idx;
    tx_shift_n = tx_shift;
    tx_pin     = 1'b1;
    case (tx_state)
      TX_IDLE: begin
        if (wr_txd && tx_en) begin
          tx_state_n = TX_START;
          tx_cnt_n   = period - 16'd1;
          tx_shift_n = bus.data_i[7:0];
        end
      end
      TX_START: begin
        tx_pin = 1'b0;
        if (tx_cnt == 16'd0) begin
          tx_state_n = TX_DATA;
          tx_cnt_n   = period - 16'd1;
          tx_idx_n   = 3'd0;
        end else begin
          tx_cnt_n = tx_cnt - 16'd1;
        end
      end
      TX_DATA: begin
        tx_pin = tx_shift[0];
        if (tx_cnt == 16'd0) begin
          tx_cnt_n = period - 16'd1;
          if (tx_idx == 3'd7) begin
            tx_state_n = TX_STOP;
          end else begin
            tx_shift_n = {1'b0, tx_shift[7:1]};
            tx_idx_n   = tx_idx + 3'd1;
          end
        end else begin
          tx_cnt_n = tx_cnt - 16'd1;
        end
      end
      TX_STOP: begin
        tx_pin = 1'b1;
        if (tx_cnt == 16'd0) tx_state_n = TX_IDLE;
        else                 tx_cnt_n   = tx_cnt - 16'd1;
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // RX synchronizer, edge-detect history and RX state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= 16'd0;
      rx_idx   <= 3'd0;
      rx_shift <= 8'd0;
    end else begin
      rx_s1    <= rx_pin;
      rx_s2    <= rx_s1;
      rx_s3    <= rx_s2;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_idx   <= rx_idx_n;
      rx_shift <= rx_shift_n;
    end
  end

  // RX next-state; a framing error just drops back to IDLE, and the
  // falling-edge requirement keeps it from re-arming until the line goes high.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_idx_n   = rx_idx;
    rx_shift_n = rx_shift;
    rx_done    = 1'b0;
    if (!rx_en) begin
      rx_state_n = RX_IDLE;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (rx_s3 && !rx_s2) begin
            rx_state_n = RX_START;
            rx_cnt_n   = half - 16'd1;
          end
        end
        RX_START: begin
          if (rx_cnt == 16'd0) begin
            if (!rx_s2) begin
              rx_state_n = RX_DATA;
              rx_cnt_n   = period - 16'd1;
              rx_idx_n   = 3'd0;
            end else begin
              rx_state_n = RX_IDLE;
            end
          end else begin
            rx_cnt_n = rx_cnt - 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == 16'd0) begin
            rx_shift_n = {rx_s2, rx_shift[7:1]};
            rx_cnt_n   = period - 16'd1;
            if (rx_idx == 3'd7) rx_state_n = RX_STOP;
            else                rx_idx_n   = rx_idx + 3'd1;
          end else begin
            rx_cnt_n = rx_cnt - 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == 16'd0) begin
            rx_state_n = RX_IDLE;
            rx_done    = rx_s2;
          end else begin
            rx_cnt_n = rx_cnt - 16'd1;
          end
        end
        default: rx_state_n = RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rib.sv
// Directed testbench for uart_rib: register access, TX framing, RX framing,
// flags and reset behaviour.
module tb_uart_rib;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_pin;
  logic       rx_pin = 1'b1;
  int         errors = 0;
  int         checks = 0;
  logic [9:0] f;

  uart_rib_if bus();

  uart_rib #(.BAUD_RST(16'd434), .ADDR_W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .tx_pin (tx_pin),
    .rx_pin (rx_pin)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    bus.we_i   = 1'b0;
    bus.addr_i = a;
    #1;
    check(tag, bus.data_o, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.we_i   = 1'b1;
    bus.addr_i = a;
    bus.data_i = d;
    @(negedge clk);
    bus.we_i   = 1'b0;
  endtask

  // 80 cycles of frame at an 8-cycle bit; optional STATUS W1C of rx_valid at cycle clr_at.
  task automatic rx_frame(input logic [7:0] b, input logic stop, input int clr_at);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      rx_pin = fr[k/8];
      if (k == clr_at) begin
        bus.we_i   = 1'b1;
        bus.addr_i = 32'h04;
        bus.data_i = 32'h2;
      end else begin
        bus.we_i = 1'b0;
      end
    end
    @(negedge clk);
    rx_pin   = 1'b1;
    bus.we_i = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    bus.we_i   = 1'b0;
    bus.addr_i = 32'd0;
    bus.data_i = 32'd0;

    // reset values
    repeat (2) @(negedge clk);
    rd(32'h00, 32'h0, "rst_ctrl");
    rd(32'h04, 32'h0, "rst_status");
    rd(32'h08, 32'd434, "rst_baud");
    rd(32'h10, 32'h0, "rst_rxdata");
    rd(32'h0C, 32'h0, "rst_txdata");
    check("rst_tx_pin", 32'(tx_pin), 32'h1);
    rst = 1'b1;
    @(negedge clk);

    // decode: upper address bits ignored, unmapped reads 0
    wr(32'h108, 32'h4);
    rd(32'h08, 32'h4, "baud_alias");
    rd(32'h14, 32'h0, "unmapped");

    // TXDATA write with tx_en=0 is dropped
    wr(32'h0C, 32'h55);
    rd(32'h04, 32'h0, "tx_dis_busy");
    check("tx_dis_pin", 32'(tx_pin), 32'h1);

    wr(32'h00, 32'h1);
    rd(32'h00, 32'h1, "ctrl_rw");

    // 0xA5 at 4 cycles/bit; 0x3C written while busy must be dropped
    f = {1'b1, 8'hA5, 1'b0};
    wr(32'h0C, 32'hA5);
    for (int i = 0; i < 40; i++) begin
      rd(32'h04, 32'h1, "tx_busy_a5");
      check("tx_bit_a5", 32'(tx_pin), 32'(f[i/4]));
      if (i == 5) begin
        bus.addr_i = 32'h0C;
        bus.data_i = 32'h3C;
        bus.we_i   = 1'b1;
      end
      @(negedge clk);
    end
    rd(32'h04, 32'h0, "tx_done_a5");
    for (int i = 0; i < 20; i++) begin
      check("tx_drop_3c", 32'(tx_pin), 32'h1);
      @(negedge clk);
    end
    rd(32'h04, 32'h0, "tx_drop_busy");

    // BAUD=1 clamps to 4; clearing tx_en mid-frame does not abort
    wr(32'h08, 32'h1);
    wr(32'h0C, 32'hFF);
    for (int i = 0; i < 40; i++) begin
      rd(32'h04, 32'h1, "tx_busy_clamp");
      check("tx_bit_clamp", 32'(tx_pin), (i < 4) ? 32'h0 : 32'h1);
      if (i == 10) begin
        bus.addr_i = 32'h00;
        bus.data_i = 32'h0;
        bus.we_i   = 1'b1;
      end
      @(negedge clk);
    end
    rd(32'h04, 32'h0, "tx_done_clamp");
    rd(32'h00, 32'h0, "ctrl_cleared");

    // RX at BAUD=8
    wr(32'h08, 32'h8);
    wr(32'h00, 32'h2);
    rx_frame(8'h5A, 1'b1, -1);
    rd(32'h10, 32'h5A, "rx_data_5a");
    rd(32'h04, 32'h2, "rx_status_5a");
    rx_frame(8'hC3, 1'b1, -1);
    rd(32'h04, 32'h6, "rx_overrun");
    rd(32'h10, 32'hC3, "rx_data_c3");
    wr(32'h04, 32'h6);
    rd(32'h04, 32'h0, "rx_w1c");
    wr(32'h10, 32'hFF);
    rd(32'h10, 32'hC3, "rxdata_ro");

    // 2-cycle glitch rejected, then a good frame proves RX back in IDLE
    @(negedge clk);
    rx_pin = 1'b0;
    repeat (2) @(negedge clk);
    rx_pin = 1'b1;
    repeat (12) @(negedge clk);
    rd(32'h04, 32'h0, "glitch_flags");
    rx_frame(8'h81, 1'b1, -1);
    rd(32'h10, 32'h81, "rx_data_81");
    rd(32'h04, 32'h2, "rx_status_81");

    // framing error: nothing changes
    rx_frame(8'h99, 1'b0, -1);
    rd(32'h10, 32'h81, "frame_err_data");
    rd(32'h04, 32'h2, "frame_err_status");

    // W1C of rx_valid on the completion cycle: set wins, no overrun
    rx_frame(8'h3E, 1'b1, 78);
    rd(32'h04, 32'h2, "w1c_vs_set");
    rd(32'h10, 32'h3E, "w1c_vs_set_data");

    // reset in the middle of a TX frame
    wr(32'h00, 32'h1);
    wr(32'h0C, 32'h00);
    repeat (10) @(negedge clk);
    check("tx_midframe", 32'(tx_pin), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_pin", 32'(tx_pin), 32'h1);
    rd(32'h04, 32'h0, "rst_mid_status");
    rd(32'h08, 32'd434, "rst_mid_baud");
    rd(32'h00, 32'h0, "rst_mid_ctrl");
    rd(32'h10, 32'h0, "rst_mid_rxdata");
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_pin", 32'(tx_pin), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
